// File: rtl/iir_pkg.sv
// Shared types, coefficient indices and saturation helper for the biquad cascade.
// Optional rounding is selected by defining IIR_ROUND_EN (see iir_mac).
package iir_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFb1,
    StFb2,
    StWn,
    StFf0,
    StFf1,
    StFf2,
    StDone
  } state_e;

  typedef enum logic [2:0] {
    MacHold,
    MacLoad,
    MacSub,
    MacAdd,
    MacAddQ,
    MacClr
  } mac_op_e;

  localparam int K_B0 = 0;
  localparam int K_B1 = 1;
  localparam int K_B2 = 2;
  localparam int K_A1 = 3;
  localparam int K_A2 = 4;

  localparam int unsigned DEF_FRAC = 14;
  localparam int unsigned ONE_Q = 1 << DEF_FRAC;

  // Clamp a signed value to the range of a signed integer of the given width.
  function automatic logic signed [63:0] sat(input logic signed [63:0] value,
                                             input int unsigned width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/iir_mac.sv
// Shared multiply-accumulator for the biquad cascade, with saturating requantisation.
// Define IIR_ROUND_EN to round half up before every right shift by FRAC.
module iir_mac
  import iir_pkg::*;
#(
  parameter int unsigned DW   = 12,
  parameter int unsigned CW   = 16,
  parameter int unsigned SW   = 16,
  parameter int unsigned FRAC = 14,
  parameter int unsigned ACCW = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           i_op,
  input  logic signed [CW-1:0] i_coef,
  input  logic signed [SW-1:0] i_oper,
  input  logic signed [DW-1:0] i_load,
  output logic signed [SW-1:0] o_wn,
  output logic signed [DW-1:0] o_x
);

`ifdef IIR_ROUND_EN
  localparam logic signed [ACCW-1:0] RND = ACCW'(1) <<< (FRAC - 1);
`endif

  logic signed [ACCW-1:0]    r_acc;
  logic signed [ACCW-1:0]    w_acc_d;
  logic signed [ACCW-1:0]    w_prod_ext;
  logic signed [ACCW-1:0]    w_sum;
  logic signed [ACCW-1:0]    w_dif;
  logic signed [ACCW-1:0]    w_load_sh;
  logic signed [ACCW-1:0]    w_q_sec;
  logic signed [CW+SW-1:0]   w_coef_x;
  logic signed [CW+SW-1:0]   w_oper_x;
  logic signed [CW+SW-1:0]   w_prod;
  logic signed [DW-1:0]      w_x_sec;

  function automatic logic signed [ACCW-1:0] quant(input logic signed [ACCW-1:0] v);
`ifdef IIR_ROUND_EN
    return (v + RND) >>> FRAC;
`else
    return v >>> FRAC;
`endif
  endfunction

  function automatic logic signed [63:0] ext64(input logic signed [ACCW-1:0] v);
    return {{(64 - ACCW){v[ACCW-1]}}, v};
  endfunction

  assign w_coef_x   = {{SW{i_coef[CW-1]}}, i_coef};
  assign w_oper_x   = {{CW{i_oper[SW-1]}}, i_oper};
  assign w_prod     = w_coef_x * w_oper_x;
  assign w_prod_ext = {{(ACCW - CW - SW){w_prod[CW+SW-1]}}, w_prod};
  assign w_sum      = r_acc + w_prod_ext;
  assign w_dif      = r_acc - w_prod_ext;
  assign w_load_sh  = {{(ACCW - DW){i_load[DW-1]}}, i_load} <<< FRAC;

  // Section output is requantised on the final add so the next section starts from x <<< FRAC.
  assign w_x_sec = DW'(sat(ext64(quant(w_sum)), DW));
  assign w_q_sec = {{(ACCW - DW){w_x_sec[DW-1]}}, w_x_sec} <<< FRAC;

  assign o_wn = SW'(sat(ext64(quant(r_acc)), SW));
  assign o_x  = DW'(r_acc >>> FRAC);

  always_comb begin
    w_acc_d = r_acc;
    unique case (i_op)
      MacLoad: w_acc_d = w_load_sh;
      MacSub:  w_acc_d = w_dif;
      MacAdd:  w_acc_d = w_sum;
      MacAddQ: w_acc_d = w_q_sec;
      MacClr:  w_acc_d = '0;
      default: w_acc_d = r_acc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_acc_d;
    end
  end

endmodule

// File: rtl/iir_sos_cascade.sv
// Cascade of Direct-Form-II biquads sharing one time-multiplexed MAC; coefficients run-time loadable.
// Define IIR_ROUND_EN for round-half-up requantisation instead of truncation.
module iir_sos_cascade
  import iir_pkg::*;
#(
  parameter int unsigned SECTIONS = 3,
  parameter int unsigned DW       = 12,
  parameter int unsigned CW       = 16,
  parameter int unsigned FRAC     = DEF_FRAC,
  parameter int unsigned SW       = 16,
  parameter int unsigned ACCW     = 40
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic signed [DW-1:0]                 in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic signed [DW-1:0]                 out_data,
  output logic                                 out_valid,
  input  logic                                 cfg_we,
  input  logic [$clog2(5*SECTIONS)-1:0]        cfg_addr,
  input  logic signed [CW-1:0]                 cfg_data,
  input  logic                                 clr
);

  localparam int unsigned NCOEF = 5 * SECTIONS;
  localparam int unsigned AW    = $clog2(NCOEF);
  localparam int unsigned SCW   = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
  localparam logic [AW-1:0]  NCOEF_A  = AW'(NCOEF);
  localparam logic [SCW-1:0] S_LAST   = SCW'(SECTIONS - 1);
  localparam logic [CW-1:0]  COEF_ONE = CW'(64'd1 << FRAC);

  state_e                r_state;
  logic [SCW-1:0]        r_s;
  logic                  r_ready;
  logic                  r_valid;
  logic signed [DW-1:0]  r_out;
  logic signed [SW-1:0]  r_wn;
  logic signed [CW-1:0]  r_coef [NCOEF];
  logic signed [SW-1:0]  r_w1 [SECTIONS];
  logic signed [SW-1:0]  r_w2 [SECTIONS];

  logic                  w_idle;
  logic                  w_accept;
  mac_op_e               w_op;
  logic [AW-1:0]         w_base;
  logic [AW-1:0]         w_cidx;
  logic signed [CW-1:0]  w_coef;
  logic signed [SW-1:0]  w_oper;
  logic signed [SW-1:0]  w_wn;
  logic signed [DW-1:0]  w_x;

  assign w_idle   = (r_state == StIdle);
  assign w_accept = in_valid & r_ready;
  assign w_base   = AW'(r_s) * AW'(5);
  assign w_coef   = r_coef[w_cidx];

  assign in_ready  = r_ready;
  assign out_valid = r_valid;
  assign out_data  = r_out;

  always_comb begin
    w_op   = MacHold;
    w_cidx = w_base;
    w_oper = '0;
    unique case (r_state)
      StIdle: if (w_accept) w_op = MacLoad;
      StFb1: begin
        w_op   = MacSub;
        w_cidx = w_base + AW'(K_A1);
        w_oper = r_w1[r_s];
      end
      StFb2: begin
        w_op   = MacSub;
        w_cidx = w_base + AW'(K_A2);
        w_oper = r_w2[r_s];
      end
      StWn: w_op = MacClr;
      StFf0: begin
        w_op   = MacAdd;
        w_cidx = w_base + AW'(K_B0);
        w_oper = r_wn;
      end
      StFf1: begin
        w_op   = MacAdd;
        w_cidx = w_base + AW'(K_B1);
        w_oper = r_w1[r_s];
      end
      StFf2: begin
        w_op   = MacAddQ;
        w_cidx = w_base + AW'(K_B2);
        w_oper = r_w2[r_s];
      end
      default: w_op = MacHold;
    endcase
  end

  iir_mac #(
    .DW   (DW),
    .CW   (CW),
    .SW   (SW),
    .FRAC (FRAC),
    .ACCW (ACCW)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .i_op   (w_op),
    .i_coef (w_coef),
    .i_oper (w_oper),
    .i_load (in_data),
    .o_wn   (w_wn),
    .o_x    (w_x)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_s     <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_out   <= '0;
      r_wn    <= '0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_state <= StFb1;
            r_s     <= '0;
            r_ready <= 1'b0;
          end
        end
        StFb1: r_state <= StFb2;
        StFb2: r_state <= StWn;
        StWn: begin
          r_wn    <= w_wn;
          r_state <= StFf0;
        end
        StFf0: r_state <= StFf1;
        StFf1: r_state <= StFf2;
        StFf2: begin
          if (r_s == S_LAST) begin
            r_state <= StDone;
          end else begin
            r_s     <= r_s + SCW'(1);
            r_state <= StFb1;
          end
        end
        StDone: begin
          r_out   <= w_x;
          r_valid <= 1'b1;
          r_ready <= 1'b1;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Config and clear take effect on the accept edge, ahead of the first coefficient/state read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCOEF; i++) begin
        r_coef[i] <= ((i % 5) == K_B0) ? COEF_ONE : '0;
      end
      for (int i = 0; i < SECTIONS; i++) begin
        r_w1[i] <= '0;
        r_w2[i] <= '0;
      end
    end else begin
      if (w_idle && cfg_we && (cfg_addr < NCOEF_A)) begin
        r_coef[cfg_addr] <= cfg_data;
      end
      if (w_idle && clr) begin
        for (int i = 0; i < SECTIONS; i++) begin
          r_w1[i] <= '0;
          r_w2[i] <= '0;
        end
      end else if (r_state == StFf2) begin
        r_w2[r_s] <= r_w1[r_s];
        r_w1[r_s] <= r_wn;
      end
    end
  end

endmodule
